// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32I constants, fetch entry type and PC helper
//
// Purpose: common definitions imported by the fetch stage files.
// Ports: none (package).
package rv32_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with clear, count and push/pop at full
//
// Purpose: small in-order buffer used for prefetched instructions and for the
// outstanding-request address tags.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_clr           synchronous clear (wins over push/pop)
//   i_push          write i_push_data (accepted when not full, or when popping)
//   i_push_data     entry to write
//   i_pop           drop the head entry (ignored when empty)
//   o_head          current head entry
//   o_count         number of entries held
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop & ~w_empty;
  // At full the slot being written is the one being read out this cycle.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push & ~i_clr) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction fetch stage with prefetch FIFO and IF/ID register
//
// Purpose: owns the fetch PC, issues credit-limited requests to instruction
// memory, buffers in-order responses, drops stale responses after a redirect
// and drives the IF/ID register under StallF/StallD/FlushD.
// Optional build macro: FETCH_PERF_EN adds perf_fetch_cnt, perf_drop_cnt and
// perf_bubble_cnt outputs.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   StallF, StallD, FlushD         hazard controls
//   PCSrc, PCTargetE               redirect from EX
//   imem_req_valid/ready/addr      request channel
//   imem_rsp_valid/data            in-order response channel
//   InstrD, PCD, PCPlus4D, ValidD  IF/ID register
module fetch_unit import rv32_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_drop_cnt,
  output logic [31:0]     perf_bubble_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = 8;
  localparam logic [CW:0] LP_DEPTH = (CW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0] r_pc;
  logic [DW-1:0]   r_drop_cnt;
  logic [CW-1:0]   w_fifo_count;
  logic [CW-1:0]   w_live_cnt;
  logic [XLEN-1:0] w_tag_head;
  fetch_entry_t    w_fifo_head;
  fetch_entry_t    w_fifo_in;
  logic            w_kill;
  logic            w_credit;
  logic            w_req_fire;
  logic            w_rsp_drop;
  logic            w_rsp_live;
  logic            w_rsp_keep;
  logic            w_advance;
  logic            w_fifo_pop;
  logic            w_fifo_push;
  logic            w_bypass;

  assign w_kill   = PCSrc | FlushD;
  // Buffered plus still-wanted in-flight entries may never exceed the FIFO.
  assign w_credit = ({1'b0, w_fifo_count} + {1'b0, w_live_cnt}) < LP_DEPTH;

  assign imem_req_valid = ~rst & ~StallF & ~PCSrc & w_credit;
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  assign w_rsp_drop = imem_rsp_valid & (r_drop_cnt != '0);
  assign w_rsp_live = imem_rsp_valid & (r_drop_cnt == '0);
  // A live response landing in the redirect cycle is already stale.
  assign w_rsp_keep = w_rsp_live & ~PCSrc;

  assign w_advance   = ~w_kill & ~StallD;
  assign w_fifo_pop  = w_advance & (w_fifo_count != '0);
  assign w_bypass    = w_advance & (w_fifo_count == '0) & w_rsp_keep;
  assign w_fifo_push = w_rsp_keep & ~w_bypass;

  assign w_fifo_in.instr = imem_rsp_data;
  assign w_fifo_in.pc    = w_tag_head;

  // Tag queue: addresses of accepted requests whose responses are still
  // wanted; its occupancy is the live count.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_q (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (PCSrc),
    .i_push      (w_req_fire),
    .i_push_data (r_pc),
    .i_pop       (w_rsp_live),
    .o_head      (w_tag_head),
    .o_count     (w_live_cnt)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_data_q (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (PCSrc),
    .i_push      (w_fifo_push),
    .i_push_data (w_fifo_in),
    .i_pop       (w_fifo_pop),
    .o_head      (w_fifo_head),
    .o_count     (w_fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_drop_cnt <= '0;
    end else if (PCSrc) begin
      r_pc <= PCTargetE;
      // Every in-flight response becomes stale; the one arriving now is consumed.
      r_drop_cnt <= r_drop_cnt + DW'(w_live_cnt) - DW'(imem_rsp_valid);
    end else begin
      if (w_req_fire) r_pc <= r_pc + 32'd4;
      if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (w_kill) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      if (w_fifo_count != '0) begin
        InstrD   <= w_fifo_head.instr;
        PCD      <= w_fifo_head.pc;
        PCPlus4D <= pc_plus4(w_fifo_head.pc);
        ValidD   <= 1'b1;
      end else if (w_bypass) begin
        InstrD   <= imem_rsp_data;
        PCD      <= w_tag_head;
        PCPlus4D <= pc_plus4(w_tag_head);
        ValidD   <= 1'b1;
      end else begin
        InstrD   <= NOP_INSTR;
        PCD      <= '0;
        PCPlus4D <= '0;
        ValidD   <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic w_load_bubble;
  assign w_load_bubble = w_kill | (w_advance & (w_fifo_count == '0) & ~w_rsp_keep);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt  <= '0;
      perf_drop_cnt   <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (w_rsp_keep)                   perf_fetch_cnt  <= perf_fetch_cnt + 32'd1;
      if (imem_rsp_valid & ~w_rsp_keep) perf_drop_cnt   <= perf_drop_cnt + 32'd1;
      if (w_load_bubble)                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
  import rv32_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD, PCSrc;
  logic [31:0] PCTargetE;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_drop_cnt, perf_bubble_cnt;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrc(PCSrc), .PCTargetE(PCTargetE),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_drop_cnt(perf_drop_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory model: in-order, one response per cycle, latency in [lat_min, lat_max].
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h1234};
  endfunction

  // Reference: program-order request stream and decode stream.
  logic [31:0] exp_req_pc, exp_id_pc, last_req_addr;
  logic        last_acc;
  int          nvalid = 0;

  task automatic model_reset();
    mq.delete();
    last_due   = 0;
    exp_req_pc = RPC;
    exp_id_pc  = RPC;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    check({tag, "_req_addr"}, imem_req_addr, RPC);
    check({tag, "_instr"}, InstrD, NOP_INSTR);
    check({tag, "_pcd"}, PCD, 32'd0);
    check({tag, "_pc4"}, PCPlus4D, 32'd0);
    check({tag, "_valid"}, {31'd0, ValidD}, 32'd0);
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input logic stf, input logic std, input logic fld,
                      input logic pcs, input logic [31:0] tgt, input logic rdy);
    logic        rsp;
    logic [31:0] p_instr, p_pc, p_pc4, acc_addr;
    logic        p_valid;
    int          d;
    StallF = stf; StallD = std; FlushD = fld; PCSrc = pcs; PCTargetE = tgt;
    imem_req_ready = rdy;
    rsp = (mq.size() != 0) && (mq[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? memf(mq[0].addr) : $urandom;
    #1;
    last_acc      = imem_req_valid & rdy;
    last_req_addr = imem_req_addr;
    acc_addr      = imem_req_addr;
    if (imem_req_valid) check("req_addr", imem_req_addr, exp_req_pc);
    check("req_gated", {31'd0, imem_req_valid & (stf | pcs)}, 32'd0);
    p_instr = InstrD; p_pc = PCD; p_pc4 = PCPlus4D; p_valid = ValidD;
    @(posedge clk);
    if (rsp) void'(mq.pop_front());
    if (last_acc) begin
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq.push_back('{addr: acc_addr, due: d});
      exp_req_pc = exp_req_pc + 32'd4;
    end
    if (pcs) exp_req_pc = tgt;
    cyc++;
    @(negedge clk);
    if (pcs | fld) begin
      check("kill_valid", {31'd0, ValidD}, 32'd0);
    end else if (std) begin
      check("hold_instr", InstrD, p_instr);
      check("hold_pcd", PCD, p_pc);
      check("hold_pc4", PCPlus4D, p_pc4);
      check("hold_valid", {31'd0, ValidD}, {31'd0, p_valid});
    end else if (ValidD) begin
      check("stream_pcd", PCD, exp_id_pc);
      check("stream_instr", InstrD, memf(exp_id_pc));
      check("stream_pc4", PCPlus4D, exp_id_pc + 32'd4);
      exp_id_pc = exp_id_pc + 32'd4;
      nvalid++;
    end
    if (!ValidD) begin
      check("bubble_instr", InstrD, NOP_INSTR);
      check("bubble_pcd", PCD, 32'd0);
      check("bubble_pc4", PCPlus4D, 32'd0);
    end
    if (pcs) exp_id_pc = tgt;
  endtask

  initial begin
    logic [31:0] saved, a0;
    int          acc_n;
    logic        seen;
`ifdef FETCH_PERF_EN
    logic [31:0] drop0;
`endif
    rst = 1'b1; StallF = 0; StallD = 0; FlushD = 0; PCSrc = 0; PCTargetE = 0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // 1-cycle memory, no stalls: back-to-back requests, one instruction per cycle.
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 32'd0, 1);
      check("t1_acc", {31'd0, last_acc}, 32'd1);
      check("t1_valid", {31'd0, ValidD}, {31'd0, (i > 0)});
    end

    // Redirect with 1-cycle memory: two bubbles then the target.
    step(0, 0, 0, 1, 32'h200, 1);
    step(0, 0, 0, 0, 32'd0, 1);
    check("t2_bubble2", {31'd0, ValidD}, 32'd0);
    step(0, 0, 0, 0, 32'd0, 1);
    check("t2_target_valid", {31'd0, ValidD}, 32'd1);
    check("t2_target_pcd", PCD, 32'h200);

    // Redirect with two requests in flight on a 3-cycle memory.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 12 && mq.size() != 2; i++) step(0, 0, 0, 0, 32'd0, 1);
    check("t3_two_outstanding", mq.size(), 32'd2);
`ifdef FETCH_PERF_EN
    drop0 = perf_drop_cnt;
`endif
    step(0, 0, 0, 1, 32'h100, 1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(0, 0, 0, 0, 32'd0, 1);
      seen = ValidD;
    end
    check("t3_seen", {31'd0, seen}, 32'd1);
    check("t3_pcd", PCD, 32'h100);
    check("t3_pc4", PCPlus4D, 32'h104);
`ifdef FETCH_PERF_EN
    check("t3_perf_drop", perf_drop_cnt - drop0, 32'd2);
`endif

    // StallD for 4 cycles: bounded prefetch, then no loss on release.
    lat_min = 1; lat_max = 1;
    repeat (6) step(0, 0, 0, 0, 32'd0, 1);
    saved = InstrD;
    acc_n = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 32'd0, 1);
      acc_n += int'(last_acc);
      check("t4_instr_held", InstrD, saved);
    end
    check("t4_acc_bound", {31'd0, acc_n <= DEPTH}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 32'd0, 1);
      check("t4_drain_valid", {31'd0, ValidD}, 32'd1);
    end

    // FlushD pulse alone: one bubble, buffered stream continues.
    saved = PCD;
    step(0, 0, 1, 0, 32'd0, 1);
    check("t5_flush_valid", {31'd0, ValidD}, 32'd0);
    check("t5_flush_instr", InstrD, 32'h0000_0013);
    step(0, 0, 0, 0, 32'd0, 1);
    check("t5_next_valid", {31'd0, ValidD}, 32'd1);
    check("t5_next_pcd", PCD, saved + 32'd4);

    // Memory not ready for 5 cycles.
    step(0, 0, 0, 0, 32'd0, 0);
    a0 = last_req_addr;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 32'd0, 0);
      check("t6_addr_stable", last_req_addr, a0);
    end
    check("t6_bubble", {31'd0, ValidD}, 32'd0);
    step(0, 0, 0, 0, 32'd0, 1);
    check("t6_resume_addr", last_req_addr, a0);
    check("t6_resume_acc", {31'd0, last_acc}, 32'd1);

    // PC wrap at the top of the address space.
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 1);
    step(0, 0, 0, 0, 32'd0, 1);
    check("t7_top_addr", last_req_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 32'd0, 1);
    check("t7_wrap_addr", last_req_addr, 32'h0000_0000);
    check("t7_top_pcd", PCD, 32'hFFFF_FFFC);
    check("t7_top_pc4", PCPlus4D, 32'h0000_0000);

    // Randomized traffic against the stream model, with a mid-run reset.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        #2 rst = 1'b1;
        #1 check_reset("midrst");
        StallF = 0; StallD = 0; FlushD = 0; PCSrc = 0;
        imem_req_ready = 0; imem_rsp_valid = 0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
      end
      step(($urandom % 5) == 0, ($urandom % 4) == 0, ($urandom % 20) == 0,
           ($urandom % 25) == 0, $urandom & 32'hFFFF_FFFC, ($urandom % 4) != 0);
    end
    check("progress", {31'd0, nvalid > 200}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
